// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int PORT_IFETCH = 0;
   localparam int PORT_DATA   = 1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way picker producing a one-hot grant.
// A lone requester always wins; on a tie the port not granted last wins,
// unless fixed priority is selected, in which case the data port wins.
module rr_pick2
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   input  logic       i_fixed_prio,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = 2'b00;
      if (i_req == 2'b11) begin
         if (i_fixed_prio || !i_last) begin
            o_gnt[PORT_DATA] = 1'b1;
         end else begin
            o_gnt[PORT_IFETCH] = 1'b1;
         end
      end else begin
         o_gnt = i_req;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single memory port.
// Define MEM_ARBITER_FIXED_PRIO_EN for fixed data-port priority on ties.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    req,
   input  logic [1:0]    we,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic [1:0]    gnt,
   output logic [1:0]    resp_valid,
   output logic [DW-1:0] resp_rdata,
   output logic          memread,
   output logic          memwrite,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_writedata,
   input  logic [DW-1:0] mem_readdata,
   input  logic          mem_ready
);

   state_t        r_state;
   state_t        w_state_next;
   logic          r_post_rst;
   logic          r_owner;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_rdata;

   logic          w_last;
   logic          w_fixed;
   logic [1:0]    w_pick;
   logic          w_win;
   logic          w_can_grant;
   logic          w_busy;
   logic          w_resp;

   // Grants are blocked while reset is high and for one cycle after it.
   assign w_can_grant = (r_state == IDLE) && !reset && !r_post_rst;

   rr_pick2 u_pick (
      .i_req        (req),
      .i_last       (w_last),
      .i_fixed_prio (w_fixed),
      .o_gnt        (w_pick)
   );

   assign gnt   = w_can_grant ? w_pick : 2'b00;
   assign w_win = w_pick[PORT_DATA];

`ifdef MEM_ARBITER_FIXED_PRIO_EN
   assign w_fixed = 1'b1;
   assign w_last  = 1'b0;
`else
   logic r_last;

   assign w_fixed = 1'b0;
   assign w_last  = r_last;

   // Starts at the data port so the fetch port wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last <= 1'b1;
      end else if (|gnt) begin
         r_last <= w_win;
      end
   end
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (|gnt) w_state_next = BUSY;
         BUSY:    if (mem_ready) w_state_next = RESP;
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_post_rst <= 1'b1;
         r_owner    <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
      end else begin
         r_state    <= w_state_next;
         r_post_rst <= 1'b0;
         if (|gnt) begin
            r_owner <= w_win;
            r_we    <= we[w_win];
            r_addr  <= w_win ? addr1 : addr0;
            r_wdata <= w_win ? wdata1 : wdata0;
         end
         if ((r_state == BUSY) && mem_ready && !r_we) begin
            r_rdata <= mem_readdata;
         end
      end
   end

   // Outputs are gated by reset so an aborted access shows nothing.
   assign w_busy = (r_state == BUSY) && !reset;
   assign w_resp = (r_state == RESP) && !reset;

   assign memread       = w_busy && !r_we;
   assign memwrite      = w_busy && r_we;
   assign mem_addr      = w_busy ? r_addr : '0;
   assign mem_writedata = w_busy ? r_wdata : '0;
   assign resp_rdata    = (w_resp && !r_we) ? r_rdata : '0;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_resp
         assign resp_valid[gi] = w_resp && (r_owner == 1'(gi));
      end
   endgenerate

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random two-port traffic against a
// queue-based reference model, plus directed latency/stall/reset cases.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   typedef struct {
      logic [1:0]    oh;
      logic [DW-1:0] rdata;
   } resp_t;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } acc_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    req;
   logic [1:0]    we;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic [1:0]    gnt;
   logic [1:0]    resp_valid;
   logic [DW-1:0] resp_rdata;
   logic          memread;
   logic          memwrite;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_writedata;
   logic [DW-1:0] mem_readdata;
   logic          mem_ready;

   logic          auto_mem;
   logic          auto_ready;
   logic [DW-1:0] auto_data;
   logic          man_ready;
   logic [DW-1:0] man_data;

   int            n_cmp = 0;
   int            n_err = 0;
   int            model_last;
   logic [DW-1:0] model_mem [16];
   logic [DW-1:0] dev_mem [16];
   resp_t         resp_q [$];
   acc_t          acc_q [$];

   assign mem_ready    = auto_mem ? auto_ready : man_ready;
   assign mem_readdata = auto_mem ? auto_data : man_data;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .we            (we),
      .addr0         (addr0),
      .addr1         (addr1),
      .wdata0        (wdata0),
      .wdata1        (wdata1),
      .gnt           (gnt),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata),
      .memread       (memread),
      .memwrite      (memwrite),
      .mem_addr      (mem_addr),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_ready     (mem_ready)
   );

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] onehot(input int p);
      return (p == 1) ? 2'b10 : 2'b01;
   endfunction

   // Lone requester wins; a tie goes to the port not granted last (or data if fixed).
   function automatic int model_pick(input logic [1:0] p);
      if (p == 2'b01) return 0;
      if (p == 2'b10) return 1;
      if (FIXED) return 1;
      return (model_last == 1) ? 0 : 1;
   endfunction

   task automatic do_round(input logic [1:0] pat, input logic [1:0] w,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      logic [1:0]    pending;
      logic [1:0]    g;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            p;
      int            waited;
      resp_t         r;
      acc_t          c;
      @(negedge clk);
      we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
      req = pat;
      pending = pat;
      waited = 0;
      while (pending != 2'b00) begin
         #1;
         g = gnt;
         if (g != 2'b00) begin
            p = model_pick(pending);
            check("grant", 96'(g), 96'(onehot(p)));
            a = (p == 1) ? a1 : a0;
            d = (p == 1) ? d1 : d0;
            c.wr = w[p]; c.addr = a; c.wdata = d;
            acc_q.push_back(c);
            r.oh = onehot(p);
            r.rdata = w[p] ? '0 : model_mem[a[5:2]];
            if (w[p]) model_mem[a[5:2]] = d;
            resp_q.push_back(r);
            model_last = p;
            pending = pending & ~g;
         end
         waited++;
         if (waited > 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_timeout: pending=%b still waiting, required a grant", pending);
            pending = 2'b00;
         end
         @(negedge clk);
         req = pending;
      end
   endtask

   task automatic manual_access(input int port, input logic wr, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input int stall, input logic [DW-1:0] rd);
      logic [1:0] oh;
      resp_t      r;
      oh = onehot(port);
      @(negedge clk);
      req = oh; we = {wr, wr}; addr0 = a; addr1 = a; wdata0 = d; wdata1 = d;
      #1;
      check("man_grant", 96'(gnt), 96'(onehot(model_pick(oh))));
      model_last = port;
      r.oh = oh;
      r.rdata = wr ? '0 : rd;
      resp_q.push_back(r);
      for (int k = 0; k <= stall; k++) begin
         @(negedge clk);
         req = ~oh;
         man_ready = (k == stall);
         man_data = (k == stall) ? rd : $urandom;
         #1;
         check("busy_hold", 96'({gnt, memread, memwrite, mem_addr, mem_writedata}),
               96'({2'b00, ~wr, wr, a, d}));
      end
      @(negedge clk);
      man_ready = 1'b0;
      req = 2'b00;
      #1;
      check("resp_latency", 96'({resp_valid, resp_rdata}), 96'({oh, r.rdata}));
   endtask

   // Response monitor
   initial begin
      resp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (resp_valid !== 2'b00) begin
            if (resp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL resp_unexpected: got valid=%b rdata=%h, required none", resp_valid, resp_rdata);
            end else begin
               e = resp_q.pop_front();
               $display("resp valid=%b rdata=%h", resp_valid, resp_rdata);
               check("resp", 96'({resp_valid, resp_rdata}), 96'({e.oh, e.rdata}));
            end
         end
      end
   end

   // Memory device: random stall, checks the access it sees against the grant order
   initial begin
      acc_t cur;
      int   stall;
      bit   in_acc;
      in_acc = 1'b0;
      stall = 0;
      auto_ready = 1'b0;
      auto_data = '0;
      forever begin
         @(negedge clk);
         #1;
         auto_ready = 1'b0;
         auto_data = $urandom;
         if (auto_mem && (memread || memwrite)) begin
            if (!in_acc) begin
               in_acc = 1'b1;
               stall = $urandom_range(0, 3);
               if (acc_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL mem_unexpected: got access addr=%h, required none", mem_addr);
                  cur.wr = memwrite; cur.addr = mem_addr; cur.wdata = mem_writedata;
               end else begin
                  cur = acc_q.pop_front();
                  check("mem_access", 96'({memwrite, memread, mem_addr, mem_writedata}),
                        96'({cur.wr, ~cur.wr, cur.addr, cur.wdata}));
               end
            end else begin
               check("mem_hold", 96'({memwrite, memread, mem_addr, mem_writedata}),
                     96'({cur.wr, ~cur.wr, cur.addr, cur.wdata}));
            end
            if (stall == 0) begin
               auto_ready = 1'b1;
               if (memread) auto_data = dev_mem[mem_addr[5:2]];
               else dev_mem[mem_addr[5:2]] = mem_writedata;
               in_acc = 1'b0;
            end else begin
               stall--;
            end
         end else begin
            in_acc = 1'b0;
            if (auto_mem) auto_ready = ($urandom_range(0, 5) == 0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]    pat;
      logic [1:0]    w;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = 32'h1000_0000 + 32'(i);
         dev_mem[i]   = 32'h1000_0000 + 32'(i);
      end
      model_last = 1;
      reset = 1'b1; req = 2'b11; we = 2'b00;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      auto_mem = 1'b0; man_ready = 1'b1; man_data = 32'h0BAD_0BAD;

      repeat (3) @(negedge clk);
      #1;
      check("rst_ctrl", 96'({gnt, resp_valid, memread, memwrite}), 96'(0));
      check("rst_data", {mem_addr, mem_writedata, resp_rdata}, 96'(0));
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_ctrl", 96'({gnt, resp_valid, memread, memwrite}), 96'(0));
      check("post_rst_data", {mem_addr, mem_writedata, resp_rdata}, 96'(0));
      @(negedge clk);
      req = 2'b00;
      man_ready = 1'b0;

      // Tie after reset: read on port 0, write 0x55 to 0x20 on port 1
      auto_mem = 1'b1;
      do_round(2'b11, 2'b10, 32'h04, 32'h20, 32'h0, 32'h55);
      // Back-to-back contention
      do_round(2'b11, 2'b00, 32'h20, 32'h08, 32'h0, 32'h0);
      do_round(2'b11, 2'b01, 32'h0C, 32'h20, 32'h77, 32'h0);

      for (int n = 0; n < 150; n++) begin
         pat = 2'($urandom_range(1, 3));
         w   = 2'($urandom_range(0, 3));
         a0  = 32'($urandom_range(0, 15)) << 2;
         a1  = 32'($urandom_range(0, 15)) << 2;
         do_round(pat, w, a0, a1, $urandom, $urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      repeat (12) @(negedge clk);
      auto_mem = 1'b0;

      // Stray mem_ready while idle, then minimum-latency read
      man_ready = 1'b1; man_data = 32'hBAD0_BAD0;
      @(negedge clk);
      man_ready = 1'b0;
      manual_access(0, 1'b0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF);
      manual_access(0, 1'b0, 32'h14, 32'hAAAA_5555, 5, 32'h1234_5678);
      manual_access(1, 1'b1, 32'h28, 32'h0000_0077, 2, 32'hFFFF_0000);

      // Reset in the second BUSY cycle aborts the access
      @(negedge clk);
      req = 2'b01; we = 2'b00; addr0 = 32'h30; wdata0 = 32'h0;
      #1;
      check("abort_grant", 96'(gnt), 96'(onehot(model_pick(2'b01))));
      @(negedge clk);
      req = 2'b00;
      #1;
      check("abort_busy1", 96'({memread, memwrite, mem_addr}), 96'({2'b10, 32'h30}));
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_rst_ctrl", 96'({gnt, resp_valid, memread, memwrite}), 96'(0));
      check("abort_rst_data", {mem_addr, mem_writedata, resp_rdata}, 96'(0));
      @(negedge clk);
      reset = 1'b0; man_ready = 1'b1; man_data = 32'hCAFE_F00D; req = 2'b11;
      model_last = 1;
      #1;
      check("abort_post_ctrl", 96'({gnt, resp_valid, memread, memwrite}), 96'(0));
      check("abort_post_data", {mem_addr, mem_writedata, resp_rdata}, 96'(0));
      @(negedge clk);
      man_ready = 1'b0; req = 2'b00;
      #1;
      check("abort_idle", 96'({resp_valid, memread, memwrite}), 96'(0));

      // First tie after the aborting reset
      auto_mem = 1'b1;
      do_round(2'b11, 2'b00, 32'h18, 32'h1C, 32'h0, 32'h0);

      repeat (20) @(negedge clk);
      check("resp_q_drained", 96'(resp_q.size()), 96'(0));
      check("acc_q_drained", 96'(acc_q.size()), 96'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 32, address width of requester and memory ports.
REQ-002 Parameter: DW, 32, data width of requester and memory ports.
REQ-003 Clock and reset: single clock clk; reset is synchronous and active-high, named reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req  in  2  per-port access request; bit 0 = instruction fetch, bit 1 = data.
REQ-007 we  in  2  per-port write enable; 0 = read, 1 = write.
REQ-008 addr0, addr1  in  AW each  per-port byte address.
REQ-009 wdata0, wdata1  in  DW each  per-port write data.
REQ-010 gnt  out  2  one-hot, combinational, request accepted this cycle.
REQ-011 resp_valid  out  2  one-hot, single-cycle pulse, access complete (read data or write ack).
REQ-012 resp_rdata  out  DW  read data, valid with resp_valid.
REQ-013 memread, memwrite  out  1 each  memory strobes.
REQ-014 mem_addr  out  AW  memory address.
REQ-015 mem_writedata  out  DW  memory write data.
REQ-016 mem_readdata  in  DW  memory read data, sampled when mem_ready=1.
REQ-017 mem_ready  in  1  memory completes the current access this cycle.

Function
REQ-018 FSM states: IDLE, BUSY, RESP.
REQ-019 IDLE: with req!=0, the arbiter asserts gnt for exactly one winner; next state BUSY; it latches winner index, we, addr, wdata.
REQ-020 IDLE with req==0: gnt=0, the arbiter holds IDLE, and all memory strobes are 0.
REQ-021 BUSY: memread=~we_latched, memwrite=we_latched; mem_addr and mem_writedata are held from the latched values, constant for the whole BUSY period.
REQ-022 BUSY with mem_ready=1: the arbiter captures mem_readdata (reads only) and moves to RESP; with mem_ready=0 it stays BUSY for an unbounded wait.
REQ-023 RESP: resp_valid[owner]=1 for one cycle; resp_rdata = captured data for reads, 0 for writes; strobes 0; next state IDLE.
REQ-024 Minimum latency: gnt in cycle t, strobes in t+1, mem_ready in t+1 gives resp_valid in t+2; next gnt no earlier than t+3.
REQ-025 Round-robin: if both ports request in IDLE, the grant goes to the port not granted last; a single requester always wins.
REQ-026 The last-granted register updates only on a grant.
REQ-027 Ungranted requests are not latched; the requester holds req, we, addr, and wdata stable until gnt.
REQ-028 mem_ready outside BUSY is ignored.
REQ-029 gnt is 0 in BUSY and RESP regardless of req.
REQ-030 While not in BUSY, mem_addr and mem_writedata are 0.

Reset
REQ-031 reset sets: state=IDLE, last-granted=port 1 (so port 0 wins the first tie), latched fields 0, captured data 0.
REQ-032 During reset and in the cycle after it: gnt=0, resp_valid=0, memread=0, memwrite=0, mem_addr=0, mem_writedata=0, resp_rdata=0.
REQ-033 Reset mid-access (BUSY or RESP): the access is aborted, no resp_valid is issued, and a later mem_ready is ignored.

Configuration
REQ-034 Macro MEM_ARBITER_FIXED_PRIO_EN: when defined, port 1 (data) always wins ties and the last-granted register is not implemented.
REQ-035 When MEM_ARBITER_FIXED_PRIO_EN is undefined, round-robin per REQ-025 applies.

Structure
REQ-036 Package mem_arbiter_pkg holds the state enum (IDLE/BUSY/RESP) and the port index constants PORT_IFETCH=0 and PORT_DATA=1.
REQ-037 One sub-module, rr_pick2: a combinational 2-way picker (req, last, fixed-prio select) that outputs a one-hot grant.

Verification
REQ-038 Read on port 0 only: req=01, addr0=0x10, mem_ready in the first BUSY cycle, mem_readdata=0xDEADBEEF -> gnt=01 at t, memread=1 with mem_addr=0x10 at t+1, resp_valid=01 with resp_rdata=0xDEADBEEF at t+2.
REQ-039 Simultaneous requests after reset: req=11, port 1 write addr1=0x20 wdata1=0x55 -> gnt=01 first; port 1 granted next, with memwrite=1, mem_addr=0x20, mem_writedata=0x55, resp_valid=10, resp_rdata=0; with MEM_ARBITER_FIXED_PRIO_EN the order is reversed.
REQ-040 Stall: mem_ready is held 0 for 5 cycles -> strobes and address are stable for all 6 BUSY cycles, gnt=0 throughout, and a single resp_valid follows.
REQ-041 Reset asserted in the 2nd BUSY cycle, then mem_ready=1 -> no resp_valid, strobes 0 the cycle after reset, state IDLE.
REQ-042 Back-to-back contention: both ports hold req for 4 accesses -> grants alternate 0,1,0,1; a mem_ready pulse while IDLE has no effect.
